// File: rtl/cb_sched.sv
// Round-robin scheduler merging NREQ pulse sources onto one output line.
// Optional `CB_SCHED_BYPASS_EN` lets same-cycle arrivals win arbitration when all queues are empty.
//
// state | meaning (derived from bsy/hi; no separate state register)
// IDLE  | all pending counters zero, hi=0
// ARB   | some counter nonzero, hi=0, one grant issued per cycle
// HOLD  | hi=1, arrivals still counted, no grants
module cb_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 3
) (
  input  logic            ti,
  input  logic            ri,
  input  logic [NREQ-1:0] ai,
  input  logic            hi,
  output logic            abo,
  output logic [NREQ-1:0] go,
  output logic            bsy,
  output logic            ofo
);

  localparam int PW = $clog2(NREQ);
  localparam logic [CW-1:0] PMAX = '1;

  logic [CW-1:0]     pend     [NREQ];
  logic [CW-1:0]     pend_nxt [NREQ];
  logic [PW-1:0]     ptr;
  logic [NREQ-1:0]   pend_nz;
  logic [NREQ-1:0]   cand;
  logic [NREQ-1:0]   drop;
  logic [NREQ-1:0]   gnt_oh;
  logic [2*NREQ-1:0] rot;
  logic [PW:0]       off;
  logic [PW:0]       sum;
  logic              gnt_vld;
  logic [PW-1:0]     gnt_idx;
  logic              any_nxt;

  always_comb begin
    pend_nz = '0;
    for (int i = 0; i < NREQ; i++) pend_nz[i] = (pend[i] != '0);
  end

`ifdef CB_SCHED_BYPASS_EN
  assign cand = (pend_nz == '0) ? ai : pend_nz;
`else
  assign cand = pend_nz;
`endif

  // Rotate so bit 0 is the ptr position; the lowest set bit is the next owner.
  always_comb begin
    rot     = {cand, cand} >> ptr;
    gnt_vld = 1'b0;
    off     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_vld = 1'b1;
        off     = (PW+1)'(k);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
    gnt_idx = sum[PW-1:0];
    if (hi) gnt_vld = 1'b0;
  end

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < NREQ; i++) gnt_oh[i] = gnt_vld && (gnt_idx == PW'(i));
  end

  always_comb begin
    drop    = '0;
    any_nxt = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend_nxt[i] = pend[i];
      if (ai[i] && !gnt_oh[i]) begin
        if (pend[i] == PMAX) drop[i] = 1'b1;
        else                 pend_nxt[i] = pend[i] + CW'(1);
      end else if (!ai[i] && gnt_oh[i]) begin
        pend_nxt[i] = pend[i] - CW'(1);
      end
      if (pend_nxt[i] != '0) any_nxt = 1'b1;
    end
  end

  always_ff @(posedge ti or posedge ri) begin
    if (ri) begin
      for (int i = 0; i < NREQ; i++) pend[i] <= '0;
      ptr <= '0;
      abo <= 1'b0;
      go  <= '0;
      bsy <= 1'b0;
      ofo <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) pend[i] <= pend_nxt[i];
      abo <= gnt_vld;
      go  <= gnt_oh;
      bsy <= any_nxt;
      if (drop != '0) ofo <= 1'b1;
      if (gnt_vld) ptr <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
    end
  end

endmodule

// File: tb/tb_cb_sched.sv
// Directed + random bench for cb_sched with a cycle model feeding an expected-output queue.
module tb_cb_sched;
  localparam int NREQ = 4;
  localparam int CW   = 3;

  logic       ti = 1'b0;
  logic       ri = 1'b1;
  logic [3:0] ai = '0;
  logic       hi = 1'b0;
  logic       abo;
  logic [3:0] go;
  logic       bsy;
  logic       ofo;

  int checks = 0;
  int errs   = 0;

  logic [4:0] exp_q[$];
  logic [3:0] go_log[$];
  int m_pend[4];
  int m_ptr;
  bit m_ofo;
  int ai_cnt[4];
  int gnt_cnt[4];

  always #5 ti = ~ti;

  cb_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .ti(ti), .ri(ri), .ai(ai), .hi(hi),
    .abo(abo), .go(go), .bsy(bsy), .ofo(ofo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
    m_ptr = 0;
    m_ofo = 0;
    exp_q.delete();
  endtask

  function automatic bit m_bsy();
    bit b = 0;
    for (int i = 0; i < 4; i++) if (m_pend[i] != 0) b = 1;
    return b;
  endfunction

  task automatic model_edge(input logic [3:0] a, input logic h, output logic [3:0] eg);
    logic [3:0] cand;
    bit all0;
    int g;
    all0 = 1;
    for (int i = 0; i < 4; i++) begin
      cand[i] = (m_pend[i] != 0);
      if (cand[i]) all0 = 0;
    end
`ifdef CB_SCHED_BYPASS_EN
    if (all0) cand = a;
`endif
    g = -1;
    if (!h) begin
      for (int k = 0; k < 4; k++) begin
        int idx = (m_ptr + k) % 4;
        if (g < 0 && cand[idx]) g = idx;
      end
    end
    eg = '0;
    for (int i = 0; i < 4; i++) begin
      if (a[i] && g != i) begin
        if (m_pend[i] == 7) m_ofo = 1;
        else m_pend[i]++;
      end else if (!a[i] && g == i) begin
        m_pend[i]--;
      end
    end
    if (g >= 0) begin
      eg[g] = 1'b1;
      m_ptr = (g + 1) % 4;
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic [3:0] a, input logic h, input string tag);
    logic [3:0] eg;
    logic [4:0] e;
    ai = a;
    hi = h;
    for (int i = 0; i < 4; i++) if (a[i]) ai_cnt[i]++;
    model_edge(a, h, eg);
    exp_q.push_back({|eg, eg});
    @(posedge ti);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".out"}, {27'd0, abo, go}, {27'd0, e});
    chk({tag, ".bsy"}, {31'd0, bsy}, {31'd0, m_bsy()});
    chk({tag, ".ofo"}, {31'd0, ofo}, {31'd0, m_ofo});
    chk({tag, ".onehot"}, {31'd0, $onehot0(go) && (abo == (go != 4'd0))}, 32'd1);
    if (abo) begin
      go_log.push_back(go);
      for (int i = 0; i < 4; i++) if (go[i]) gnt_cnt[i]++;
    end
    @(negedge ti);
  endtask

  task automatic do_reset();
    ri = 1'b1;
    ai = '0;
    hi = 1'b0;
    model_reset();
    @(negedge ti);
    chk("reset.state", {25'd0, abo, go, bsy, ofo}, 32'd0);
    ri = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();

    // 1: async reset mid-queue
    do_reset();
    step(4'b1111, 1'b1, "t1.fill");
    step(4'b1001, 1'b1, "t1.fill");
    step(4'b0001, 1'b1, "t1.fill");
    step(4'b0000, 1'b0, "t1.run");
    chk("t1.abo_before", {31'd0, abo}, 32'd1);
    #2 ri = 1'b1;
    #1 chk("t1.async", {25'd0, abo, go, bsy, ofo}, 32'd0);
    model_reset();
    #1 ri = 1'b0;
    @(negedge ti);
    go_log.delete();
    for (int i = 0; i < 6; i++) step(4'b0000, 1'b0, "t1.post");
    chk("t1.no_pulses", go_log.size(), 0);
    step(4'b0010, 1'b0, "t1.new");
    step(4'b0000, 1'b0, "t1.new");

    // 2: single request latency
    do_reset();
    step(4'b0100, 1'b0, "t2.e0");
    step(4'b0000, 1'b0, "t2.e1");
    step(4'b0000, 1'b0, "t2.idle");

    // 3: all sources at once, strict rotation then wrap
    do_reset();
    go_log.delete();
    step(4'b1111, 1'b0, "t3.req");
    for (int i = 0; i < 6; i++) step(4'b0000, 1'b0, "t3.drain");
    chk("t3.count", go_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t3.order", (go_log.size() > i) ? {28'd0, go_log[i]} : 32'hffff, 32'd1 << i);
    step(4'b0001, 1'b0, "t3.wrap");
    step(4'b0000, 1'b0, "t3.wrap");
    chk("t3.wrap_owner", (go_log.size() > 4) ? {28'd0, go_log[4]} : 32'hffff, 32'd1);

    // 4: saturation under hold, then release
    do_reset();
    for (int i = 0; i < 9; i++) step(4'b0010, 1'b1, "t4.hold");
    chk("t4.ofo", {31'd0, ofo}, 32'd1);
    go_log.delete();
    for (int i = 0; i < 12; i++) step(4'b0000, 1'b0, "t4.release");
    n = 0;
    foreach (go_log[i]) if (go_log[i] == 4'b0010) n++;
    chk("t4.pulses", n, 7);
    chk("t4.total", go_log.size(), 7);
    chk("t4.bsy_end", {31'd0, bsy}, 32'd0);

    // 5: arrival on the grant edge for the granted source
    do_reset();
    step(4'b0010, 1'b0, "t5.setup");
    step(4'b0000, 1'b0, "t5.setup");
    step(4'b0100, 1'b1, "t5.load");
    go_log.delete();
    step(4'b0100, 1'b0, "t5.g1");
    step(4'b0000, 1'b0, "t5.g2");
    step(4'b0000, 1'b0, "t5.end");
    chk("t5.count", go_log.size(), 2);
    for (int i = 0; i < 2; i++)
      chk("t5.owner", (go_log.size() > i) ? {28'd0, go_log[i]} : 32'hffff, 32'd4);

    // 6: random traffic with hold toggling, then drain
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ai_cnt[i]  = 0;
      gnt_cnt[i] = 0;
    end
    for (int c = 0; c < 5000; c++) begin
      logic [3:0] a;
      for (int i = 0; i < 4; i++) a[i] = ($urandom_range(9) == 0);
      step(a, ($urandom_range(4) == 0), "t6.rand");
    end
    for (int i = 0; i < 30; i++) step(4'b0000, 1'b0, "t6.drain");
    chk("t6.ofo", {31'd0, ofo}, 32'd0);
    chk("t6.bsy", {31'd0, bsy}, 32'd0);
    for (int i = 0; i < 4; i++) chk("t6.per_source", gnt_cnt[i], ai_cnt[i]);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
